// File: rtl/adaptive_integr_fir.sv
// adaptive_integr_fir: 3-stage symmetric 4-tap integrating FIR (pre-add, multiply, round/reduce)
// with valid/ready on both sides. Define ADAPTIVE_INTEGR_SAT_EN for a saturating output and sat_flag.
module adaptive_integr_fir #(
  parameter int DIN_WL = 15,
  parameter int DIN_FL = 6,
  parameter int DOUT_WL = 14,
  parameter int DOUT_FL = 6,
  parameter logic signed [7:0] COEFF_A0 = 8'sh17,
  parameter logic signed [7:0] COEFF_A1 = 8'sh29
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DIN_WL-1:0]  s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DOUT_WL-1:0]        m_data,
  output logic                      sat_flag
);

  localparam int SUM_W = DIN_WL + 1;
  localparam int PRD_W = SUM_W + 8;
  localparam int ACC_W = PRD_W + 2;
  localparam int SH    = DIN_FL + 6 - DOUT_FL;
  localparam int Q_W   = ACC_W - SH;

  logic                      w_en;
  logic                      w_accept;
  logic signed [DIN_WL-1:0]  r_x1, r_x2, r_x3;
  logic signed [SUM_W-1:0]   w_sum0, w_sum1, r_sum0, r_sum1;
  logic                      r_s1_valid, r_s2_valid, r_m_valid;
  logic signed [PRD_W-1:0]   w_p0, w_p1, r_p0;
  logic signed [PRD_W:0]     r_p1;
  logic signed [ACC_W-1:0]   w_acc, w_rnd;
  logic signed [Q_W-1:0]     w_q;
  logic [DOUT_WL-1:0]        w_y, r_m_data;
  logic                      w_unused;

  // Whole pipeline freezes while an output is waiting; rst gating keeps s_ready low during reset.
  assign w_en     = ~r_m_valid | m_ready;
  assign s_ready  = w_en & ~clear & ~rst;
  assign w_accept = s_valid & s_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_x3 <= '0;
    end else if (clear) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_x3 <= '0;
    end else if (w_accept) begin
      r_x1 <= s_data;
      r_x2 <= r_x1;
      r_x3 <= r_x2;
    end
  end

  assign w_sum0 = {s_data[DIN_WL-1], s_data} + {r_x3[DIN_WL-1], r_x3};
  assign w_sum1 = {r_x1[DIN_WL-1], r_x1} + {r_x2[DIN_WL-1], r_x2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_sum0     <= '0;
      r_sum1     <= '0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
      r_sum0     <= '0;
      r_sum1     <= '0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      r_sum0     <= w_sum0;
      r_sum1     <= w_sum1;
    end
  end

  // A1 has one fewer fractional bit than A0; the extra shift aligns both products.
  assign w_p0 = PRD_W'(r_sum0) * PRD_W'(COEFF_A0);
  assign w_p1 = PRD_W'(r_sum1) * PRD_W'(COEFF_A1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
    end else if (clear) begin
      r_s2_valid <= 1'b0;
      r_p0       <= '0;
      r_p1       <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_p0       <= w_p0;
      r_p1       <= {w_p1, 1'b0};
    end
  end

  assign w_acc = ACC_W'(r_p0) + ACC_W'(r_p1);
  assign w_rnd = w_acc + ACC_W'(1 << (SH - 1));
  assign w_q   = w_rnd[ACC_W-1:SH];

`ifdef ADAPTIVE_INTEGR_SAT_EN
  localparam logic signed [Q_W-1:0] Q_MAX = Q_W'((1 << (DOUT_WL - 1)) - 1);
  localparam logic signed [Q_W-1:0] Q_MIN = Q_W'(-(1 << (DOUT_WL - 1)));

  logic w_clip;
  logic r_clip;
  logic r_sat;

  always_comb begin
    w_clip = 1'b0;
    w_y    = w_q[DOUT_WL-1:0];
    if (w_q > Q_MAX) begin
      w_y    = {1'b0, {(DOUT_WL-1){1'b1}}};
      w_clip = 1'b1;
    end else if (w_q < Q_MIN) begin
      w_y    = {1'b1, {(DOUT_WL-1){1'b0}}};
      w_clip = 1'b1;
    end
  end

  // Flag only clipped samples that actually leave the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip <= 1'b0;
      r_sat  <= 1'b0;
    end else if (clear) begin
      r_clip <= 1'b0;
      r_sat  <= 1'b0;
    end else begin
      if (r_m_valid && m_ready && r_clip) r_sat <= 1'b1;
      if (w_en) r_clip <= w_clip;
    end
  end

  assign sat_flag = r_sat;
  assign w_unused = ^w_rnd[SH-1:0];
`else
  assign w_y      = w_q[DOUT_WL-1:0];
  assign sat_flag = 1'b0;
  assign w_unused = ^{w_rnd[SH-1:0], w_q[Q_W-1:DOUT_WL]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (clear) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_en) begin
      r_m_valid <= r_s2_valid;
      r_m_data  <= w_y;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;

endmodule

// File: doc/adaptive_integr_fir.md
# adaptive_integr_fir

Pipelined 4-tap symmetric integrating FIR that is the inverse stage of the adaptive filter's differentiating FIR. It accepts differentiator output samples (signed, WL 15 / FL 6) over a valid/ready stream, and returns the reconstructed 14-bit signal (WL 14 / FL 6) on a second valid/ready stream with full backpressure. The block sits after the differentiator in the adaptive filter chain.

## Interface
- DIN_WL, 15, input word length (signed, two's complement)
- DIN_FL, 6, input fractional length
- DOUT_WL, 14, output word length (DATA_WIDTH of the filter)
- DOUT_FL, 6, output fractional length
- COEFF_A0, 8'h17, outer-tap coefficient, signed 8 bit, FL 6 (0.359375)
- COEFF_A1, 8'h29, inner-tap coefficient, signed 8 bit, FL 5 (1.28125)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush of delay line and pipeline
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_data  in  DIN_WL  input sample
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output
- m_data  out  DOUT_WL  output sample
- sat_flag  out  1  sticky saturation indicator

## Operation
- Transfer on a port when valid and ready are both high at a rising edge.
- Response: y[n] = A0·(x[n] + x[n-3]) + A1·(x[n-1] + x[n-2]).
- Delay line x[n-1..n-3] shifts only on an accepted input; it holds otherwise.
- Stage 1 (pre-add): two sign-extended 16-bit sums, FL 6.
- Stage 2 (multiply): 16x8 signed products. The A0 product has FL 12. The A1 product has FL 11 and is shifted left 1 to reach FL 12 (25 bits).
- Stage 3 (accumulate/quantize):
  - Form a 26-bit sum at FL 12.
  - Round half-up: add 2^5, then drop the 6 LSBs.
  - Reduce to DOUT_WL (see Configuration).
- Pipeline enable: en = ~m_valid | m_ready. Each stage advances when en is high.
- s_ready = en & ~clear.
- clear:
  - Zeroes the delay line and all stage valids on the next edge.
  - Clear wins over a simultaneous s_valid. That input is not accepted because s_ready is low.
  - A pending m_valid is dropped.
  - sat_flag is also cleared.
- Reset values: s_ready 0 while rst is high, then 1. m_valid 0, m_data 0, sat_flag 0. Delay line and pipeline registers are 0.
- Reset mid-stream: in-flight samples are discarded and no partial output is produced.

## Timing
- Latency is 3 cycles from input acceptance to m_valid with m_ready held high.
- Throughput is one sample per cycle.
- With m_ready low and m_valid high, all stages freeze and s_ready goes low in the same cycle (combinational).
  - m_data stays stable until accepted.
  - Up to 3 samples are held in flight; none are lost or duplicated.
- Bubbles (s_valid low) propagate as stage valid = 0 and do not shift the delay line.

## Configuration
- Macro: ADAPTIVE_INTEGR_SAT_EN.
- Defined:
  - Stage 3 saturates to [-2^(DOUT_WL-1), 2^(DOUT_WL-1)-1], i.e. 0x2000 .. 0x1FFF.
  - sat_flag sets on any clipped output that is accepted downstream, and stays set until rst or clear.
- Undefined:
  - Stage 3 keeps the low DOUT_WL bits (two's-complement wrap).
  - sat_flag is tied to 0.

## Test plan
- Impulse: s_data = 64 (1.0), then zeros, m_ready = 1.
  - Required m_data sequence: 23, 82, 82, 23, 0…
  - First output appears 3 cycles after acceptance.
- DC step: s_data = 64, held. Required: m_data settles to 210 (3.28125) from the 4th output onward.
- Saturation (macro defined): s_data = 16383, held.
  - Required: m_data = 0x1FFF and sat_flag = 1.
  - Then s_data = -16384 held gives m_data = 0x2000.
  - With the macro undefined, the output is the wrapped value and sat_flag = 0.
- Backpressure: stream 1, 2, 3, … with m_ready low for 5 cycles mid-stream.
  - Required: s_ready low during the stall and m_data stable.
  - The output sequence matches the unstalled golden model exactly.
- Clear/reset mid-stream: assert clear together with s_valid after 2 accepted impulse samples.
  - Required: that input is not accepted, m_valid drops, sat_flag = 0.
  - The next impulse gives 23, 82, 82, 23 with no residue.
  - Repeating the test with rst gives the same result.
- Rounding: impulse s_data = 1. Required m_data sequence: 0, 1, 1, 0 (0.359→0, 1.281→1).
